// File: rtl/sargantana_ifill_responder.sv
// ---------------------------------------------------------------------------
// sargantana_ifill_responder
//
// Upper-level responder for the icache iFill port. It accepts one line-fill
// request (line address + destination way) and issues a single burst read to
// the next memory level. It gathers NBEATS read beats into a full line and
// returns that line to the icache as a one-cycle fill response.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   ifill_req_*             fill request from the icache (valid/paddr/way/ready)
//   ifill_abort_i           icache kill/flush, drops the in-flight fill
//   ifill_resp_*            fill response (valid/ack pulses, data/way held)
//   mem_req_*               burst read request to memory (valid/ready/addr)
//   mem_resp_*              read beats from memory (no backpressure)
//   fill_latency_o          cycles taken by the last delivered fill
//
// Optional feature macro: IFILL_RESP_LAT_CNT_EN
//   defined   : 16-bit saturating fill-latency counter drives fill_latency_o
//   undefined : fill_latency_o is tied to zero
// ---------------------------------------------------------------------------
module sargantana_ifill_responder #(
    parameter int PADDR_LINE_WIDTH = 34,
    parameter int LINE_WIDTH       = 512,
    parameter int MEM_DATA_WIDTH   = 128,
    parameter int N_WAY            = 4
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             ifill_req_valid_i,
    input  logic [PADDR_LINE_WIDTH-1:0]                      ifill_req_paddr_i,
    input  logic [$clog2(N_WAY)-1:0]                         ifill_req_way_i,
    output logic                                             ifill_req_ready_o,
    input  logic                                             ifill_abort_i,
    output logic                                             ifill_resp_valid_o,
    output logic                                             ifill_resp_ack_o,
    output logic [LINE_WIDTH-1:0]                            ifill_resp_data_o,
    output logic [$clog2(N_WAY)-1:0]                         ifill_resp_way_o,
    output logic                                             mem_req_valid_o,
    input  logic                                             mem_req_ready_i,
    output logic [PADDR_LINE_WIDTH+$clog2(LINE_WIDTH/8)-1:0] mem_req_addr_o,
    input  logic                                             mem_resp_valid_i,
    input  logic [MEM_DATA_WIDTH-1:0]                        mem_resp_data_i,
    input  logic                                             mem_resp_error_i,
    output logic [15:0]                                      fill_latency_o
);

    localparam int NBEATS = LINE_WIDTH / MEM_DATA_WIDTH;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int WAY_W  = $clog2(N_WAY);

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        COLLECT,
        RESP,
        DRAIN
    } state_e;

    state_e                        state_q, state_d;
    logic [PADDR_LINE_WIDTH-1:0]   paddr_q, paddr_d;
    logic [WAY_W-1:0]              way_q, way_d;
    logic [LINE_WIDTH-1:0]         line_q, line_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          err_q, err_d;
    // Response data/way live in their own registers so they stay stable
    // while the next line is being assembled in line_q.
    logic [LINE_WIDTH-1:0]         rdata_q, rdata_d;
    logic [WAY_W-1:0]              rway_q, rway_d;

    logic beat_last;
    logic accept;
    logic resp_fire;

    assign beat_last = (cnt_q == CNT_W'(NBEATS - 1));
    assign accept    = (state_q == IDLE) && ifill_req_valid_i && !ifill_abort_i;
    assign resp_fire = (state_q == RESP) && !ifill_abort_i;

    always_comb begin
        state_d = state_q;
        paddr_d = paddr_q;
        way_d   = way_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rway_d  = rway_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    paddr_d = ifill_req_paddr_i;
                    way_d   = ifill_req_way_i;
                    line_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                // Once the handshake happens the burst is committed, so an
                // abort in the same cycle still has to swallow the beats.
                if (mem_req_ready_i) begin
                    state_d = ifill_abort_i ? DRAIN : COLLECT;
                end else if (ifill_abort_i) begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (mem_resp_valid_i) begin
                    for (int b = 0; b < NBEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            line_d[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_resp_data_i;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    err_d = err_q | mem_resp_error_i;
                    if (beat_last) begin
                        // Abort on the final beat: nothing left to drain.
                        if (ifill_abort_i) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RESP;
                            rdata_d = line_d;
                            rway_d  = way_q;
                        end
                    end else if (ifill_abort_i) begin
                        state_d = DRAIN;
                    end
                end else if (ifill_abort_i) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (mem_resp_valid_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            paddr_q <= '0;
            way_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rway_q  <= '0;
        end else begin
            state_q <= state_d;
            paddr_q <= paddr_d;
            way_q   <= way_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rway_q  <= rway_d;
        end
    end

    assign ifill_req_ready_o  = (state_q == IDLE);
    assign mem_req_valid_o    = (state_q == MEM_REQ);
    assign mem_req_addr_o     = {paddr_q, {OFF_W{1'b0}}};
    assign ifill_resp_valid_o = resp_fire;
    assign ifill_resp_ack_o   = resp_fire & ~err_q;
    assign ifill_resp_data_o  = rdata_q;
    assign ifill_resp_way_o   = rway_q;

`ifdef IFILL_RESP_LAT_CNT_EN
    logic [15:0] lat_q;
    logic [15:0] lat_inc;
    logic [15:0] lat_out_q;

    assign lat_inc = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;

    // The published value includes the RESP cycle itself, so the minimum
    // accept-to-response fill reports 6.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_q     <= '0;
            lat_out_q <= '0;
        end else begin
            lat_q <= accept ? 16'd0 : lat_inc;
            if (resp_fire) begin
                lat_out_q <= lat_inc;
            end
        end
    end

    assign fill_latency_o = lat_out_q;
`else
    assign fill_latency_o = 16'd0;
`endif

endmodule

// File: tb/tb_sargantana_ifill_responder.sv
// ---------------------------------------------------------------------------
// Testbench for sargantana_ifill_responder. Directed fills are issued by the
// stimulus process, which pushes the expected response (line, ack, way and
// response cycle) into a scoreboard queue; a negedge monitor pops and compares
// whenever the DUT pulses ifill_resp_valid_o.
// ---------------------------------------------------------------------------
module tb_sargantana_ifill_responder;

    localparam int PA_W   = 34;
    localparam int LINE_W = 512;
    localparam int MD_W   = 128;
    localparam int NWAY   = 4;
    localparam int NBEATS = LINE_W / MD_W;
    localparam int WAY_W  = 2;
    localparam int ADDR_W = 40;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic [PA_W-1:0]    req_paddr;
    logic [WAY_W-1:0]   req_way;
    logic               req_ready;
    logic               abort;
    logic               resp_valid;
    logic               resp_ack;
    logic [LINE_W-1:0]  resp_data;
    logic [WAY_W-1:0]   resp_way;
    logic               mreq_valid;
    logic               mreq_ready;
    logic [ADDR_W-1:0]  mreq_addr;
    logic               mresp_valid;
    logic [MD_W-1:0]    mresp_data;
    logic               mresp_err;
    logic [15:0]        fill_lat;

    sargantana_ifill_responder #(
        .PADDR_LINE_WIDTH(PA_W),
        .LINE_WIDTH      (LINE_W),
        .MEM_DATA_WIDTH  (MD_W),
        .N_WAY           (NWAY)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ifill_req_valid_i (req_valid),
        .ifill_req_paddr_i (req_paddr),
        .ifill_req_way_i   (req_way),
        .ifill_req_ready_o (req_ready),
        .ifill_abort_i     (abort),
        .ifill_resp_valid_o(resp_valid),
        .ifill_resp_ack_o  (resp_ack),
        .ifill_resp_data_o (resp_data),
        .ifill_resp_way_o  (resp_way),
        .mem_req_valid_o   (mreq_valid),
        .mem_req_ready_i   (mreq_ready),
        .mem_req_addr_o    (mreq_addr),
        .mem_resp_valid_i  (mresp_valid),
        .mem_resp_data_i   (mresp_data),
        .mem_resp_error_i  (mresp_err),
        .fill_latency_o    (fill_lat)
    );

    typedef struct {
        logic [LINE_W-1:0] data;
        logic              ack;
        logic [WAY_W-1:0]  way;
        int                cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_lat = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [MD_W-1:0] base);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < NBEATS; i++) l[i*MD_W +: MD_W] = base + MD_W'(i);
        return l;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && resp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk_line("resp_data", resp_data, e.data);
                chk("resp_ack", 64'(resp_ack), 64'(e.ack));
                chk("resp_way", 64'(resp_way), 64'(e.way));
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [MD_W-1:0] d, input logic e);
        mresp_valid = 1'b1;
        mresp_data  = d;
        mresp_err   = e;
        tick();
        mresp_valid = 1'b0;
        mresp_err   = 1'b0;
    endtask

    // Full fill: req_wait cycles of mem_req_ready low, gap idle cycles between
    // beats, errm marks beats carrying a bus error.
    task automatic do_fill(input logic [PA_W-1:0] pa, input logic [WAY_W-1:0] wy,
                           input int req_wait, input int gap,
                           input logic [NBEATS-1:0] errm, input logic [MD_W-1:0] base);
        exp_t e;
        int   t0;
        logic [ADDR_W-1:0] ea;
        ea        = {pa, 6'b0};
        req_valid = 1'b1;
        req_paddr = pa;
        req_way   = wy;
        t0        = cyc;
        chk("accept_ready", 64'(req_ready), 64'd1);
        e.data = mk_line(base);
        e.ack  = ~|errm;
        e.way  = wy;
        e.cyc  = t0 + 2 + req_wait + (NBEATS - 1) * (gap + 1) + 1;
        sbq.push_back(e);
        tick();
        req_valid = 1'b0;
        for (int w = 0; w <= req_wait; w++) begin
            chk("mreq_valid", 64'(mreq_valid), 64'd1);
            chk("mreq_addr", 64'(mreq_addr), 64'(ea));
            chk("busy_ready", 64'(req_ready), 64'd0);
            mreq_ready = (w == req_wait);
            tick();
        end
        mreq_ready = 1'b0;
        for (int b = 0; b < NBEATS; b++) begin
            if (b > 0) begin
                for (int g = 0; g < gap; g++) begin
                    chk("gap_ready", 64'(req_ready), 64'd0);
                    tick();
                end
            end
            beat(base + MD_W'(b), errm[b]);
        end
        // Now in the RESP cycle; the monitor checks it at the negedge.
        tick();
        chk("resp_seen", 64'(sbq.size()), 64'd0);
        chk("idle_ready", 64'(req_ready), 64'd1);
        chk_line("data_hold", resp_data, e.data);
        chk("way_hold", 64'(resp_way), 64'(wy));
`ifdef IFILL_RESP_LAT_CNT_EN
        last_lat = e.cyc - t0;
`endif
        chk("fill_latency", 64'(fill_lat), 64'(last_lat));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_paddr   = '0;
        req_way     = '0;
        abort       = 1'b0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
        mresp_err   = 1'b0;
        #2;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_mreq_valid", 64'(mreq_valid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_addr", 64'(mreq_addr), 64'd0);
        chk_line("rst_data", resp_data, '0);
        chk("rst_lat", 64'(fill_lat), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic fill, address check against hand-computed byte address
        do_fill(34'h1_0000_0040, 2'd2, 0, 0, 4'b0000, 128'hA0);
        checks++;
        if (40'h40_0000_1000 !== {34'h1_0000_0040, 6'b0}) failures++;

        // Backpressure on the request plus one idle cycle between beats
        do_fill(34'h0_1234_5678, 2'd1, 3, 1, 4'b0000, 128'h1111_0000);

        // Bus error on beat 2 only
        do_fill(34'h2_0000_0001, 2'd3, 0, 0, 4'b0100, 128'hE0);

        // Abort after beat 1: beats 2,3 drained, no response
        req_valid = 1'b1;
        req_paddr = 34'h0_0000_0100;
        req_way   = 2'd0;
        tick();
        req_valid  = 1'b0;
        mreq_ready = 1'b1;
        tick();
        mreq_ready = 1'b0;
        beat(128'hD0, 1'b0);
        beat(128'hD1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("drain_ready", 64'(req_ready), 64'd0);
        beat(128'hD2, 1'b0);
        chk("drain_ready2", 64'(req_ready), 64'd0);
        beat(128'hD3, 1'b0);
        chk("post_drain_ready", 64'(req_ready), 64'd1);
        chk("abort_lat_hold", 64'(fill_lat), 64'(last_lat));
        do_fill(34'h0_0000_0200, 2'd1, 0, 0, 4'b0000, 128'hB0);

        // Abort before the request handshake
        req_valid = 1'b1;
        req_paddr = 34'h3_0000_0000;
        req_way   = 2'd2;
        tick();
        req_valid = 1'b0;
        chk("pre_abort_mreq", 64'(mreq_valid), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_mreq_drop", 64'(mreq_valid), 64'd0);
        chk("abort_idle_ready", 64'(req_ready), 64'd1);
        tick();
        tick();
        chk("abort_mreq_stays_low", 64'(mreq_valid), 64'd0);

        // Reset in the middle of COLLECT
        req_valid = 1'b1;
        req_paddr = 34'h0_0000_0300;
        req_way   = 2'd3;
        tick();
        req_valid  = 1'b0;
        mreq_ready = 1'b1;
        tick();
        mreq_ready = 1'b0;
        beat(128'hF0, 1'b0);
        beat(128'hF1, 1'b0);
        beat(128'hF2, 1'b0);
        rst = 1'b1;
        #2;
        chk("arst_ready", 64'(req_ready), 64'd1);
        chk("arst_mreq_valid", 64'(mreq_valid), 64'd0);
        chk("arst_addr", 64'(mreq_addr), 64'd0);
        chk("arst_way", 64'(resp_way), 64'd0);
        chk_line("arst_data", resp_data, '0);
        chk("arst_lat", 64'(fill_lat), 64'd0);
        last_lat = 0;
        tick();
        rst = 1'b0;
        beat(128'hF3, 1'b0);
        tick();
        chk("stray_ignored_ready", 64'(req_ready), 64'd1);
        chk("stray_no_mreq", 64'(mreq_valid), 64'd0);
        do_fill(34'h0_0000_0400, 2'd0, 0, 0, 4'b0000, 128'hC0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sargantana_ifill_responder.md
Name: sargantana_ifill_responder

Overview:
Upper-level responder for the instruction-cache iFill interface. Accepts a line-fill request (line physical address plus destination way) from the icache and issues one burst read to the memory/L2 port. It collects the read beats into a full cache line and returns them to the icache as a single-cycle fill response. Sits between the icache iFill port and the next memory level.

Parameters:
PADDR_LINE_WIDTH, 34, width of the line address (tag plus set index, no byte offset) sent by the icache
LINE_WIDTH, 512, cache line width in bits
MEM_DATA_WIDTH, 128, memory beat width in bits; LINE_WIDTH must be a multiple of it
N_WAY, 4, icache associativity

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
ifill_req_valid_i  in  1  fill request valid
ifill_req_paddr_i  in  PADDR_LINE_WIDTH  line address
ifill_req_way_i  in  $clog2(N_WAY)  way to be filled
ifill_req_ready_o  out  1  responder can accept a request
ifill_abort_i  in  1  icache kill/flush; drop the in-flight fill
ifill_resp_valid_o  out  1  fill line valid, one-cycle pulse
ifill_resp_ack_o  out  1  same cycle as valid; 1 = line good, 0 = bus error
ifill_resp_data_o  out  LINE_WIDTH  assembled line
ifill_resp_way_o  out  $clog2(N_WAY)  echoed way
mem_req_valid_o  out  1  burst read request
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  PADDR_LINE_WIDTH+$clog2(LINE_WIDTH/8)  byte address, offset bits zero
mem_resp_valid_i  in  1  read beat valid (no backpressure)
mem_resp_data_i  in  MEM_DATA_WIDTH  read beat data, ascending beat order
mem_resp_error_i  in  1  beat carries a bus error
fill_latency_o  out  16  cycles of the last completed fill (optional feature)

Behaviour:
- NBEATS = LINE_WIDTH/MEM_DATA_WIDTH (4 by default). The beat counter is $clog2(NBEATS) bits, at least 1.
- Reset values: FSM IDLE, all registers 0, all outputs 0 except ifill_req_ready_o = 1 once in IDLE.
- FSM states: IDLE, MEM_REQ, COLLECT, RESP, DRAIN.
- IDLE:
  - ready_o = 1.
  - When valid_i is high, register paddr and way, clear the line buffer, error flag and beat counter, and go to MEM_REQ.
  - If abort_i is high in the same cycle, the request is not accepted.
- MEM_REQ:
  - mem_req_valid_o = 1 and mem_req_addr_o = {paddr_q, zeros}, both held stable until mem_req_ready_i.
  - On the handshake, go to COLLECT.
  - If abort_i is high before the handshake, drop mem_req_valid_o and return to IDLE.
  - If abort_i and ready_i are high in the same cycle, go to DRAIN.
- COLLECT:
  - Each mem_resp_valid_i writes the beat to slice [cnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH], increments cnt, and ORs error_i into a sticky error flag.
  - After beat NBEATS-1, go to RESP.
  - If abort_i is high, go to DRAIN. A beat arriving in that same cycle is still counted.
- RESP:
  - Exactly one cycle: resp_valid_o = 1, ack_o = ~error, data_o = line buffer, way_o = way_q. Then go to IDLE.
  - If abort_i is high in RESP, suppress resp_valid_o and go to IDLE.
- DRAIN:
  - Consume the remaining beats with no response. After the last beat, go to IDLE.
  - abort_i is ignored in DRAIN.
- mem_resp_valid_i is ignored in IDLE, MEM_REQ and RESP. The earliest beat is counted the cycle after the request handshake.
- resp_data_o and resp_way_o hold their value outside RESP; only valid_o and ack_o are pulses.
- Minimum latency: accept at T, request handshake at T+1, beats at T+2..T+5, response at T+6.
- Only one fill is outstanding. A new request is accepted no earlier than the cycle after RESP.
- Asserting rst_i at any time forces IDLE immediately, clears all outputs and discards any partial line. Beats still arriving are ignored because the FSM is in IDLE.

Optional Feature:
IFILL_RESP_LAT_CNT_EN defined:
- A 16-bit counter clears on request accept and increments every cycle, saturating at 16'hFFFF.
- On a delivered response (RESP, not aborted), its value is copied to fill_latency_o, which holds until the next delivered response. With T+6 timing the value is 6.
- Aborted fills do not update fill_latency_o.

Not defined:
- fill_latency_o is tied to 0 and no counter logic is synthesised.

Test Plan:
- Basic fill: req paddr=34'h1_0000_0040, way=2; mem ready immediately; 4 beats of 128'hA0..A3, no gaps -> mem_req_addr_o=40'h40_0000_1000; resp_valid_o high at T+6; data_o={A3,A2,A1,A0}; ack_o=1; way_o=2; fill_latency_o=6 with the macro.
- Backpressure and gaps: mem_req_ready_i low for 3 cycles, 1 idle cycle between each beat -> mem_req_valid_o/addr stable for 4 cycles; single resp pulse at T+12; ready_o=0 throughout.
- Error beat: mem_resp_error_i on beat 2 only -> resp_valid_o=1, ack_o=0, full line still returned.
- Abort mid-burst: abort_i after beat 1 -> DRAIN; beats 2,3 consumed; no resp_valid_o; ready_o=1 the cycle after beat 3; the next request completes normally with its own data.
- Abort before handshake: abort_i in MEM_REQ with mem_req_ready_i=0 -> mem_req_valid_o=0 next cycle; FSM IDLE; no memory beats expected.
- Reset mid-COLLECT: rst_i asserted after beat 2 -> outputs 0 asynchronously; stray beats ignored; a post-reset request returns only the new line.
